data_line_receiver: RTL and testbench

DATA_LINE_RECEIVER -- requirements
Module: data_line_receiver

---
 rtl/data_line_receiver.sv | 107 ++++++++++
 tb/tb_data_line_receiver.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/data_line_receiver.sv
// Serial frame receiver: header sync, fixed-length payload, even parity.
// One bit per clk; serial_in is resynchronized before use.
module data_line_receiver #(
  parameter int         DATA_BITS = 218,
  parameter logic [7:0] HEADER    = 8'b0111_1110
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 serial_in,
  input  logic                 game_active,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 recv_busy
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    PARITY,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic                 sbit;
  logic [7:0]           hdr_q, hdr_d, hdr_next;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] pay_q, pay_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 perr_q, perr_d;

  assign sbit     = sync2_q;
  assign hdr_next = {hdr_q[6:0], sbit};

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      hdr_q   <= '0;
      cnt_q   <= '0;
      pay_q   <= '0;
      dout_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
      pay_q   <= pay_d;
      dout_q  <= dout_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    cnt_d   = cnt_q;
    pay_d   = pay_q;
    dout_d  = dout_q;
    perr_d  = perr_q;
    if (!game_active) begin
      state_d = IDLE;
      hdr_d   = '0;
      cnt_d   = '0;
      pay_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          hdr_d = hdr_next;
          if (hdr_next == HEADER) begin
            state_d = RECV;
            cnt_d   = '0;
          end
        end
        RECV: begin
          pay_d = {pay_q[DATA_BITS-2:0], sbit};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = PARITY;
        end
        PARITY: begin
          dout_d  = pay_q;
          perr_d  = ^{pay_q, sbit};
          cnt_d   = '0;
          state_d = DONE;
        end
        DONE: begin
          // first bit after parity may already open the next header
          hdr_d   = {7'b0, sbit};
          state_d = IDLE;
        end
      endcase
    end
  end

  assign data_out   = dout_q;
  assign parity_err = perr_q;
  assign data_valid = (state_q == DONE);
  assign recv_busy  = (state_q == RECV) || (state_q == PARITY);

endmodule

// File: tb/tb_data_line_receiver.sv
// Randomized bench for data_line_receiver.
// Frames are modelled as (payload, parity, due cycle) records.
module tb_data_line_receiver;

  localparam int         DB  = 218;
  localparam logic [7:0] HDR = 8'b0111_1110;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          serial_in;
  logic          game_active;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          parity_err;
  logic          recv_busy;

  data_line_receiver #(.DATA_BITS(DB), .HEADER(HDR)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .serial_in  (serial_in),
    .game_active(game_active),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .recv_busy  (recv_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int            due;
    logic [DB-1:0] p;
    logic          pe;
  } exp_t;

  exp_t          expq[$];
  int            bfrom = 1 << 30;
  int            bto   = -1;
  logic [DB-1:0] last_out = '0;
  logic          last_pe  = 1'b0;
  logic          exp_busy;
  bit            mon_en = 1'b0;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive(input logic b);
    @(negedge clk);
    serial_in = b;
  endtask

  function automatic logic [DB-1:0] rnd_payload();
    logic [DB-1:0] r;
    for (int i = 0; i < DB; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic model_reset();
    expq.delete();
    last_out = '0;
    last_pe  = 1'b0;
    bfrom    = 1 << 30;
    bto      = -1;
  endtask

  // mode 0 normal, 1 abort at bit 50, 2 reset at bit 10,
  // 3 abort on the PARITY->DONE edge
  task automatic send_frame(input logic [DB-1:0] p, input logic par,
                            input int mode);
    exp_t e;
    int   cp;
    for (int i = 7; i >= 0; i--) drive(HDR[i]);
    bfrom = cyc + 3;
    bto   = 1 << 30;
    for (int i = DB - 1; i >= 0; i--) begin
      drive(p[i]);
      if (mode == 1 && (DB - 1 - i) == 50) begin
        game_active = 1'b0;
        bto = cyc;
        repeat (4) drive(1'b0);
        game_active = 1'b1;
        return;
      end
      if (mode == 2 && (DB - 1 - i) == 10) begin
        rst_l = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_data_out", data_out, 0);
        chk("rst_mid_valid", data_valid, 0);
        chk("rst_mid_perr", parity_err, 0);
        chk("rst_mid_busy", recv_busy, 0);
        repeat (3) drive(1'b0);
        rst_l = 1'b1;
        return;
      end
    end
    drive(par);
    cp  = cyc;
    bto = cp + 2;
    if (mode == 3) begin
      drive(1'b0);
      drive(1'b0);
      game_active = 1'b0;
      repeat (2) drive(1'b0);
      game_active = 1'b1;
      return;
    end
    e.due = cp + 3;
    e.p   = p;
    e.pe  = (^p) ^ par;
    expq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_l) begin
      exp_busy = (cyc >= bfrom) && (cyc <= bto);
      chk("recv_busy", recv_busy, exp_busy);
      if (expq.size() > 0 && expq[0].due == cyc) begin
        chk("data_valid", data_valid, 1);
        last_out = expq[0].p;
        last_pe  = expq[0].pe;
        void'(expq.pop_front());
      end else begin
        chk("data_valid", data_valid, 0);
      end
      chk("data_out", data_out, last_out);
      chk("parity_err", parity_err, last_pe);
    end
  end

  initial begin
    logic [DB-1:0] p;
    rst_l       = 1'b0;
    serial_in   = 1'b0;
    game_active = 1'b0;
    @(negedge clk);
    chk("reset_data_out", data_out, 0);
    chk("reset_valid", data_valid, 0);
    chk("reset_perr", parity_err, 0);
    chk("reset_busy", recv_busy, 0);
    @(negedge clk);
    rst_l       = 1'b1;
    game_active = 1'b1;
    mon_en      = 1'b1;
    repeat (3) drive(1'b0);

    p = '0;
    p[0] = 1'b1;
    send_frame(p, 1'b1, 0);
    repeat (3) drive(1'b0);
    send_frame(p, 1'b0, 0);
    repeat (2) drive(1'b0);

    p = rnd_payload();
    p[100:93] = 8'h7E;
    send_frame(p, ^p, 0);
    repeat (2) drive(1'b0);

    send_frame(rnd_payload(), 1'b0, 1);
    repeat (2) drive(1'b0);

    p = '1;
    send_frame(p, ^p, 0);
    p = '0;
    send_frame(p, ^p, 0);
    repeat (2) drive(1'b0);

    send_frame(rnd_payload(), 1'b1, 2);
    repeat (2) drive(1'b0);
    p = rnd_payload();
    send_frame(p, ^p, 0);
    repeat (2) drive(1'b0);

    send_frame(rnd_payload(), 1'b0, 3);
    repeat (2) drive(1'b0);

    for (int n = 0; n < 20; n++) begin
      send_frame(rnd_payload(), 1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 4)) drive(1'b0);
    end

    repeat (10) drive(1'b0);
    chk("pending_frames", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
